// File: rtl/mips_pkg.sv
// Shared MIPS definitions: text segment base and the
// instruction-memory loader state encoding.
package mips_pkg;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects little-endian bytes into 32-bit words and
// flags the cycle in which the fourth byte arrives.
module byte_word_assembler (
    input  logic        clk,
    input  logic        rstb,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_vld
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = 2'd0;
            sh_d  = 24'd0;
        end else if (byte_vld) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {byte_in, sh_q[23:8]};
        end
    end

    // The word is presented combinationally with its top byte
    // still on the input, so the consumer sees it on the 4th edge.
    assign word     = {byte_in, sh_q};
    assign word_vld = byte_vld && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rstb) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills instruction memory and
// holds the core in reset until a checksummed load completes.
module imem_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = mips_pkg::TEXT_BASE,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_wr_ena,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wr_data,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    ld_state_e   state_q, state_d;
    logic [7:0]  n_lo_q, n_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] k_q, k_d;
    logic [31:0] sum_q, sum_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        acc;
    logic        asm_vld;
    logic [31:0] word;
    logic        word_vld;
    logic [15:0] n_hdr;

    // A byte offered alongside restart is dropped.
    assign acc     = in_valid && in_ready && !restart;
    assign asm_vld = acc && (state_q == ST_DATA || state_q == ST_CSUM);
    assign n_hdr   = {in_data, n_lo_q};

    byte_word_assembler u_asm (
        .clk      (clk),
        .rstb     (rstb),
        .clr      (restart),
        .byte_vld (asm_vld),
        .byte_in  (in_data),
        .word     (word),
        .word_vld (word_vld)
    );

    always_ff @(posedge clk) begin
        if (rstb) state_q <= ST_HDR0;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_HDR0;
        end else begin
            unique case (state_q)
                ST_HDR0: if (acc) state_d = ST_HDR1;
                ST_HDR1: begin
                    if (acc) begin
                        if (n_hdr > MAX_W)      state_d = ST_ERR;
                        else if (n_hdr == 16'd0) state_d = ST_CSUM;
                        else                     state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_vld && k_q == n_q - 16'd1)
                        state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (word_vld)
                        state_d = (word == sum_q) ? ST_DONE : ST_ERR;
                end
                ST_DONE: state_d = ST_DONE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_HDR0;
            endcase
        end
    end

    always_comb begin
        n_lo_d  = n_lo_q;
        n_d     = n_q;
        k_d     = k_q;
        sum_d   = sum_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (restart) begin
            k_d   = 16'd0;
            sum_d = 32'd0;
        end else begin
            if (acc && state_q == ST_HDR0) n_lo_d = in_data;
            if (acc && state_q == ST_HDR1) n_d = n_hdr;
            if (word_vld && state_q == ST_DATA) begin
                wr_d    = 1'b1;
                addr_d  = TEXT_BASE + {14'd0, k_q, 2'b00};
                wdata_d = word;
                k_d     = k_q + 16'd1;
                sum_d   = sum_q + word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            n_lo_q  <= 8'd0;
            n_q     <= 16'd0;
            k_q     <= 16'd0;
            sum_q   <= 32'd0;
            wr_q    <= 1'b0;
            addr_q  <= TEXT_BASE;
            wdata_q <= 32'd0;
        end else begin
            n_lo_q  <= n_lo_d;
            n_q     <= n_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        in_ready     = (state_q != ST_DONE) && (state_q != ST_ERR);
        core_hold    = (state_q != ST_DONE);
        done         = (state_q == ST_DONE);
        err          = (state_q == ST_ERR);
        imem_wr_ena  = wr_q;
        imem_addr    = addr_q;
        imem_wr_data = wdata_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum errors,
// size limits, input gaps, restart and reset cancellation.
module tb_imem_loader;

    localparam logic [31:0] TB = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        imem_wr_ena;
    logic [31:0] imem_addr;
    logic [31:0] imem_wr_data;
    logic        core_hold;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] w16[16];
    logic [31:0] s16;
    int base;

    imem_loader dut (
        .clk          (clk),
        .rstb         (rstb),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_wr_ena  (imem_wr_ena),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Write log, sampled at the rising edge (pre-update values).
    always @(posedge clk) begin
        if (imem_wr_ena === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            put(w[8*i +: 8]);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic run16(input bit gaps, input string tag);
        base = wa.size();
        put(8'h10);
        put(8'h00);
        for (int i = 0; i < 16; i++) put_word(w16[i], gaps);
        put_word(s16, gaps);
        check({tag, "_nwr"}, 32'(wa.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wa.size()) begin
                check({tag, "_addr"}, wa[base+i], TB + 32'(4*i));
                check({tag, "_data"}, wd[base+i], w16[i]);
            end
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wr_ena", {31'd0, imem_wr_ena}, 32'd0);
        check("rst_addr", imem_addr, TB);
        check("rst_wdata", imem_wr_data, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rstb = 1'b0;
        @(negedge clk);

        // 3-word good frame, checksum = sum of the words
        base = wa.size();
        put(8'h03);
        put(8'h00);
        put_word(32'h2001_0001, 1'b0);
        put_word(32'h2002_0002, 1'b0);
        put_word(32'h0810_000B, 1'b0);
        check("w3_lat", {31'd0, imem_wr_ena}, 32'd1);
        put_word(32'h4813_000E, 1'b0);
        check("w3_nwr", 32'(wa.size() - base), 32'd3);
        if (wa.size() >= base + 3) begin
            check("w3_a0", wa[base], 32'h0040_0000);
            check("w3_a1", wa[base+1], 32'h0040_0004);
            check("w3_a2", wa[base+2], 32'h0040_0008);
            check("w3_d0", wd[base], 32'h2001_0001);
            check("w3_d2", wd[base+2], 32'h0810_000B);
        end
        check("w3_done", {31'd0, done}, 32'd1);
        check("w3_hold", {31'd0, core_hold}, 32'd0);
        check("w3_err", {31'd0, err}, 32'd0);
        check("w3_ready", {31'd0, in_ready}, 32'd0);

        // Same frame, bad checksum
        pulse_restart();
        check("rs_done_clr", {31'd0, done}, 32'd0);
        base = wa.size();
        put(8'h03);
        put(8'h00);
        put_word(32'h2001_0001, 1'b0);
        put_word(32'h2002_0002, 1'b0);
        put_word(32'h0810_000B, 1'b0);
        put_word(32'h0000_0000, 1'b0);
        check("bad_nwr", 32'(wa.size() - base), 32'd3);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_hold", {31'd0, core_hold}, 32'd1);
        check("bad_ready", {31'd0, in_ready}, 32'd0);

        // Empty frame
        pulse_restart();
        base = wa.size();
        put(8'h00);
        put(8'h00);
        put_word(32'h0, 1'b0);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_nwr", 32'(wa.size() - base), 32'd0);

        // Oversize header: 1025 words
        pulse_restart();
        put(8'h01);
        check("big_err_b1", {31'd0, err}, 32'd0);
        put(8'h04);
        check("big_err", {31'd0, err}, 32'd1);
        check("big_ready", {31'd0, in_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("big_nwr", 32'(wa.size() - base), 32'd0);

        // 16 words, gap-free then with random gaps
        s16 = 32'd0;
        for (int i = 0; i < 16; i++) begin
            w16[i] = 32'hF000_0000 + 32'(i) * 32'h1357_9BDF;
            s16 = s16 + w16[i];
        end
        pulse_restart();
        run16(1'b0, "g0");
        pulse_restart();
        run16(1'b1, "gap");

        // Restart mid-word on word index 1 with a byte offered
        pulse_restart();
        base = wa.size();
        put(8'h03);
        put(8'h00);
        put_word(32'h1111_2222, 1'b0);
        put(8'hAA);
        put(8'hBB);
        in_data  = 8'h77;
        in_valid = 1'b1;
        restart  = 1'b1;
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        check("rs_nwr", 32'(wa.size() - base), 32'd1);
        check("rs_ready", {31'd0, in_ready}, 32'd1);
        base = wa.size();
        put(8'h01);
        put(8'h00);
        put_word(32'h1234_5678, 1'b0);
        put_word(32'h1234_5678, 1'b0);
        check("rl_nwr", 32'(wa.size() - base), 32'd1);
        if (wa.size() > base) begin
            check("rl_addr", wa[base], TB);
            check("rl_data", wd[base], 32'h1234_5678);
        end
        check("rl_done", {31'd0, done}, 32'd1);

        // Reset on the edge that takes a 4th byte
        pulse_restart();
        base = wa.size();
        put(8'h01);
        put(8'h00);
        put(8'hBE);
        put(8'hBA);
        put(8'hFE);
        in_data  = 8'hCA;
        in_valid = 1'b1;
        rstb     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rb_wr_ena", {31'd0, imem_wr_ena}, 32'd0);
        check("rb_addr", imem_addr, TB);
        check("rb_wdata", imem_wr_data, 32'd0);
        check("rb_ready", {31'd0, in_ready}, 32'd1);
        check("rb_hold", {31'd0, core_hold}, 32'd1);
        check("rb_done", {31'd0, done}, 32'd0);
        check("rb_err", {31'd0, err}, 32'd0);
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        check("rb_nwr", 32'(wa.size() - base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
